// File: rtl/pmod_adc_block.sv
// pmod_adc_block: SPI read-side controller for a CS-framed serial ADC.
// Ports: i_clk, i_rst (async, active-high), i_start, i_continuous,
//   o_busy, o_dout, o_dout_valid, o_frame_err, o_adc_cs_n, o_adc_sclk,
//   i_adc_din. Frame is FRAME_BITS MSB-first; dout holds the low
//   RESOLUTION bits, frame_err flags nonzero leading bits.
module pmod_adc_block #(
  parameter int RESOLUTION   = 12,
  parameter int FRAME_BITS   = 16,
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_continuous,
  output logic                  o_busy,
  output logic [RESOLUTION-1:0] o_dout,
  output logic                  o_dout_valid,
  output logic                  o_frame_err,
  output logic                  o_adc_cs_n,
  output logic                  o_adc_sclk,
  input  logic                  i_adc_din
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(QUIET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_t;

  state_t r_state, w_state_n;

  logic [DW-1:0]         r_div, w_div_n;
  logic                  r_ph, w_ph_n;
  logic [BW-1:0]         r_bit, w_bit_n;
  logic [QW-1:0]         r_q, w_q_n;
  logic                  w_shift;
  logic                  w_done;
  logic                  w_err;
  logic [1:0]            r_sync;
  logic [FRAME_BITS-1:0] r_sh;

  // r_ph: 0 = low half of the SCLK period, 1 = high half
  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_ph_n    = r_ph;
    w_bit_n   = r_bit;
    w_q_n     = r_q;
    w_shift   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_state_n = S_SETUP;
      end
      S_SETUP: begin
        if (r_div == DIV_LAST) w_state_n = S_SHIFT;
        else w_div_n = r_div + 1'b1;
      end
      S_SHIFT: begin
        if (r_div != DIV_LAST) begin
          w_div_n = r_div + 1'b1;
        end else begin
          w_div_n = '0;
          if (!r_ph) begin
            w_ph_n  = 1'b1;
            w_shift = 1'b1;
          end else if (r_bit == BIT_LAST) begin
            w_state_n = S_DONE;
          end else begin
            w_ph_n  = 1'b0;
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_done    = 1'b1;
        w_state_n = S_QUIET;
      end
      S_QUIET: begin
        if (r_q == Q_LAST)
          w_state_n = i_continuous ? S_SETUP : S_IDLE;
        else
          w_q_n = r_q + 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
    // every state starts with fresh counters
    if (w_state_n != r_state) begin
      w_div_n = '0;
      w_ph_n  = 1'b0;
      w_bit_n = '0;
      w_q_n   = '0;
    end
  end

  generate
    if (FRAME_BITS > RESOLUTION) begin : g_err
      assign w_err = |r_sh[FRAME_BITS-1:RESOLUTION];
    end else begin : g_noerr
      assign w_err = 1'b0;
    end
  endgenerate

  // pins are registered from the next state so they line up with it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_ph         <= 1'b0;
      r_bit        <= '0;
      r_q          <= '0;
      r_sync       <= '0;
      r_sh         <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
      o_adc_cs_n   <= 1'b1;
      o_adc_sclk   <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_div        <= w_div_n;
      r_ph         <= w_ph_n;
      r_bit        <= w_bit_n;
      r_q          <= w_q_n;
      r_sync       <= {r_sync[0], i_adc_din};
      if (w_shift)
        r_sh <= {r_sh[FRAME_BITS-2:0], r_sync[1]};
      if (w_done) begin
        o_dout      <= r_sh[RESOLUTION-1:0];
        o_frame_err <= w_err;
      end
      o_dout_valid <= w_done;
      o_busy       <= (w_state_n != S_IDLE);
      o_adc_cs_n   <= !((w_state_n == S_SETUP) ||
                        (w_state_n == S_SHIFT));
      o_adc_sclk   <= !((w_state_n == S_SHIFT) && !w_ph_n);
    end
  end

endmodule
